// File: rtl/pc_sequencer.sv
// Program-counter sequencer for the MIPS fetch stage with single-delay-slot redirects.
// Optional simulation trace: define PC_SEQUENCER_TRACE_EN.
module pc_sequencer #(
  parameter int                WIDTH        = 32,
  parameter logic [WIDTH-1:0]  RESET_VECTOR = WIDTH'(32'hBFC00000),
  parameter int                STEP         = 4,
  parameter int                ALIGN_BITS   = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clk_enable,
  input  logic             stall,
  input  logic             redirect_valid,
  input  logic [WIDTH-1:0] redirect_target,
  output logic [WIDTH-1:0] pc_out,
  output logic [WIDTH-1:0] link_addr,
  output logic             in_delay_slot,
  output logic             halted,
  output logic             addr_err
);

  localparam logic [1:0] ST_RUN    = 2'd0;
  localparam logic [1:0] ST_DELAY  = 2'd1;
  localparam logic [1:0] ST_HALTED = 2'd2;

  localparam logic [WIDTH-1:0] STEP_INC   = WIDTH'(STEP);
  localparam logic [WIDTH-1:0] LINK_OFS   = WIDTH'(2 * STEP);
  localparam logic [WIDTH-1:0] ALIGN_MASK = WIDTH'((64'd1 << ALIGN_BITS) - 64'd1);

  logic [1:0]       state;
  logic [1:0]       state_nxt;
  logic [WIDTH-1:0] target_q;
  logic [WIDTH-1:0] target_nxt;
  logic [WIDTH-1:0] pc_nxt;
  logic [WIDTH-1:0] pc_seq;
  logic             err_nxt;
  logic             advance;
  logic             target_aligned;

  assign advance        = clk_enable & ~stall & ~reset;
  assign pc_seq         = pc_out + STEP_INC;
  assign target_aligned = (redirect_target & ALIGN_MASK) == '0;
  assign link_addr      = pc_out + LINK_OFS;
  assign in_delay_slot  = (state == ST_DELAY);
  assign halted         = (state == ST_HALTED);

  // A redirect is only accepted in RUN; the delay slot and HALTED ignore redirect_valid.
  always_comb begin
    state_nxt  = state;
    target_nxt = target_q;
    pc_nxt     = pc_out;
    err_nxt    = 1'b0;
    if (advance) begin
      case (state)
        ST_RUN: begin
          pc_nxt = pc_seq;
          if (redirect_valid) begin
            if (target_aligned) begin
              target_nxt = redirect_target;
              state_nxt  = ST_DELAY;
            end else begin
              err_nxt = 1'b1;
            end
          end
        end
        ST_DELAY: begin
          pc_nxt    = target_q;
          state_nxt = (target_q == '0) ? ST_HALTED : ST_RUN;
        end
        ST_HALTED: begin
          state_nxt = ST_HALTED;
        end
        default: begin
          state_nxt = ST_RUN;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_out   <= RESET_VECTOR;
      state    <= ST_RUN;
      target_q <= '0;
      addr_err <= 1'b0;
    end else begin
      pc_out   <= pc_nxt;
      state    <= state_nxt;
      target_q <= target_nxt;
      addr_err <= err_nxt;
    end
  end

`ifdef PC_SEQUENCER_TRACE_EN
  always @(posedge clk) begin
    $display("CPU : PC : %h state=%0d", pc_out, state);
  end
`endif

endmodule
